// File: rtl/mmio_fabric_buf.sv
// MMIO bus decode into N_SLOT slot strobes, with a posted-write FIFO and reads ordered behind pending writes.
// Optional error capture of unmapped accesses is compiled in when MMIO_ERR_CAPTURE_EN is defined.
module mmio_fabric_buf #(
  parameter  int ADDR_W   = 21,
  parameter  int DW       = 32,
  parameter  int REG_AW   = 5,
  parameter  int SLOT_AW  = 6,
  parameter  int N_USED   = 14,
  parameter  int WF_DEPTH = 4,
  localparam int N_SLOT   = 2**SLOT_AW,
  localparam int AW       = REG_AW + SLOT_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mmio_cs,
  input  logic                 mmio_wr,
  input  logic                 mmio_rd,
  input  logic [ADDR_W-1:0]    mmio_addr,
  input  logic [DW-1:0]        mmio_wr_data,
  output logic                 mmio_ready,
  output logic [DW-1:0]        mmio_rd_data,
  output logic                 mmio_rd_valid,
  output logic [N_SLOT-1:0]    slot_cs_array,
  output logic [N_SLOT-1:0]    slot_mem_rd_array,
  output logic [N_SLOT-1:0]    slot_mem_wr_array,
  output logic [REG_AW-1:0]    slot_reg_addr,
  output logic [DW-1:0]        slot_wr_data,
  input  logic [N_SLOT*DW-1:0] slot_rd_data_flat,
  input  logic                 err_clr,
  output logic                 err_flag,
  output logic [AW-1:0]        err_addr
);

  localparam int PTR_W = $clog2(WF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [SLOT_AW:0] N_USED_V = N_USED[SLOT_AW:0];
  localparam logic [CNT_W-1:0] FULL_CNT = WF_DEPTH[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_AW-1:0]  rd_slot_q, rd_slot_d;
  logic [REG_AW-1:0]   rd_reg_q, rd_reg_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;

  logic [SLOT_AW-1:0]  fifo_slot_q [WF_DEPTH];
  logic [REG_AW-1:0]   fifo_reg_q  [WF_DEPTH];
  logic [DW-1:0]       fifo_data_q [WF_DEPTH];

  logic [DW-1:0]       slot_rd_word [N_SLOT];

  logic [SLOT_AW-1:0]  in_slot, head_slot;
  logic [REG_AW-1:0]   in_reg, head_reg;
  logic [DW-1:0]       head_data;
  logic                accept, push, rd_accept, fifo_empty, fifo_full, pop, rd_fire, rd_used;
  logic                unused_addr;

  assign in_slot     = mmio_addr[REG_AW +: SLOT_AW];
  assign in_reg      = mmio_addr[REG_AW-1:0];
  assign unused_addr = ^mmio_addr[ADDR_W-1:AW];

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign mmio_ready = (state_q == IDLE) && !fifo_full;

  // A simultaneous wr+rd request is treated purely as a write.
  assign accept    = mmio_cs && (mmio_wr || mmio_rd) && mmio_ready;
  assign push      = accept && mmio_wr;
  assign rd_accept = accept && !mmio_wr;

  assign pop       = !fifo_empty;
  assign head_slot = fifo_slot_q[rptr_q];
  assign head_reg  = fifo_reg_q[rptr_q];
  assign head_data = fifo_data_q[rptr_q];

  // The read strobe only fires once every earlier posted write has left the FIFO.
  assign rd_fire = (state_q == RD_WAIT) && fifo_empty;
  assign rd_used = ({1'b0, rd_slot_q} < N_USED_V);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_slot_q[wptr_q] <= in_slot;
      fifo_reg_q[wptr_q]  <= in_reg;
      fifo_data_q[wptr_q] <= mmio_wr_data;
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_d   = state_q;
    rd_slot_d = rd_slot_q;
    rd_reg_d  = rd_reg_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (rd_accept) begin
          rd_slot_d = in_slot;
          rd_reg_d  = in_reg;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (fifo_empty) begin
          rd_data_d = rd_used ? slot_rd_word[rd_slot_q] : '0;
          state_d   = RD_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rd_slot_q <= '0;
      rd_reg_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      rd_slot_q <= rd_slot_d;
      rd_reg_q  <= rd_reg_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign mmio_rd_data  = rd_data_q;
  assign mmio_rd_valid = (state_q == RD_DONE);

  for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
    assign slot_rd_word[gi] = slot_rd_data_flat[gi*DW +: DW];
    if (gi < N_USED) begin : g_used
      assign slot_mem_wr_array[gi] = pop && (head_slot == SLOT_AW'(gi));
      assign slot_mem_rd_array[gi] = rd_fire && (rd_slot_q == SLOT_AW'(gi));
    end else begin : g_absent
      assign slot_mem_wr_array[gi] = 1'b0;
      assign slot_mem_rd_array[gi] = 1'b0;
    end
  end

  assign slot_cs_array = slot_mem_wr_array | slot_mem_rd_array;

  always_comb begin
    slot_reg_addr = '0;
    slot_wr_data  = '0;
    if (pop) begin
      slot_reg_addr = head_reg;
      slot_wr_data  = head_data;
    end else if (rd_fire) begin
      slot_reg_addr = rd_reg_q;
    end
  end

`ifdef MMIO_ERR_CAPTURE_EN
  logic          err_flag_q, err_flag_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic          err_new;

  assign err_new = accept && ({1'b0, in_slot} >= N_USED_V);

  // A new error in the same cycle as err_clr wins, and re-arms the address capture.
  always_comb begin
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      err_flag_d = 1'b0;
      err_addr_d = '0;
    end
    if (err_new) begin
      err_flag_d = 1'b1;
      if (!err_flag_q || err_clr) begin
        err_addr_d = {in_slot, in_reg};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_flag       = 1'b0;
  assign err_addr       = '0;
`endif

endmodule
